// File: rtl/detectfaces_sdiv_25s_16ns_9s_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle.
// Quotient saturates to the signed dout range; remainder follows dividend sign.
module detectfaces_sdiv_25s_16ns_9s_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 25,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 9
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ce,
  input  logic                    start,
  input  logic [din0_WIDTH-1:0]   din0,
  input  logic [din1_WIDTH-1:0]   din1,
  output logic                    busy,
  output logic                    done,
  output logic [dout_WIDTH-1:0]   dout,
  output logic [din1_WIDTH:0]     rem,
  output logic                    ovf,
  output logic                    dbz
);

  localparam int RW = din1_WIDTH + 1;
  localparam int CW = $clog2(din0_WIDTH + 1);

  localparam logic [din0_WIDTH-1:0] QMAX =
    din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
  localparam logic [din0_WIDTH-1:0] QMIN =
    din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
  localparam logic [dout_WIDTH-1:0] SMAX =
    {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SMIN =
    {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t                  state;
  // acc shifts dividend bits out the top and quotient bits in the bottom
  logic [din0_WIDTH-1:0]   acc;
  logic [din1_WIDTH-1:0]   dvs;
  logic [RW-1:0]           r;
  logic [RW-1:0]           orig;
  logic                    neg;
  logic [CW-1:0]           cnt;

  logic [din0_WIDTH-1:0]   mag;
  logic [RW-1:0]           r_sh;
  logic                    ge;
  logic [RW-1:0]           r_nx;
  logic                    ovf_nx;
  logic [dout_WIDTH-1:0]   dout_nx;
  logic [RW-1:0]           rem_nx;

  assign mag  = din0[din0_WIDTH-1] ? -din0 : din0;
  assign r_sh = {r[din1_WIDTH-1:0], acc[din0_WIDTH-1]};
  assign ge   = r_sh >= {1'b0, dvs};
  assign r_nx = ge ? r_sh - {1'b0, dvs} : r_sh;

  always_comb begin
    ovf_nx  = 1'b0;
    dout_nx = acc[dout_WIDTH-1:0];
    rem_nx  = r;
    if (dvs == '0) begin
      dout_nx = neg ? SMIN : SMAX;
      rem_nx  = orig;
    end else if (neg) begin
      ovf_nx  = acc > QMIN;
      dout_nx = ovf_nx ? SMIN : -acc[dout_WIDTH-1:0];
      rem_nx  = -r;
    end else begin
      ovf_nx  = acc > QMAX;
      dout_nx = ovf_nx ? SMAX : acc[dout_WIDTH-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      dvs   <= '0;
      r     <= '0;
      orig  <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= mag;
            dvs   <= din1;
            orig  <= din0[RW-1:0];
            neg   <= din0[din0_WIDTH-1];
            r     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= {acc[din0_WIDTH-2:0], ge};
          r   <= r_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(din0_WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          dout  <= dout_nx;
          rem   <= rem_nx;
          ovf   <= ovf_nx;
          dbz   <= (dvs == '0);
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detectfaces_sdiv_25s_16ns_9s_seq.sv
// Directed and random checks of the sequential divider against C-style
// integer division with saturation.
module tb_detectfaces_sdiv_25s_16ns_9s_seq;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        start;
  logic [24:0] din0;
  logic [15:0] din1;
  logic        busy;
  logic        done;
  logic [8:0]  dout;
  logic [16:0] rem;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  detectfaces_sdiv_25s_16ns_9s_seq dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ce       (ce),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input longint a, input longint b,
                       output int q, output int r,
                       output int ov, output int bz);
    longint qt;
    logic [16:0] lo;
    if (b == 0) begin
      lo = a[16:0];
      bz = 1;
      ov = 0;
      r  = int'($signed(lo));
      q  = (a >= 0) ? 255 : -256;
    end else begin
      qt = a / b;
      r  = int'(a % b);
      bz = 0;
      ov = (qt > 255 || qt < -256) ? 1 : 0;
      q  = (qt > 255) ? 255 : (qt < -256) ? -256 : int'(qt);
    end
  endtask

  task automatic op(input longint a, input longint b,
                    input int ce_at, input int re_at, input string tag);
    int q, r, ov, bz, k, lat, extra;
    bit seen;
    model(a, b, q, r, ov, bz);
    lat = (ce_at >= 0) ? 30 : 27;
    @(negedge clk);
    din0  = a[24:0];
    din1  = b[15:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din0  = 25'($urandom);
    din1  = 16'($urandom);
    chk({tag, ":busy"}, int'(busy), 1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (k == ce_at) ce = 1'b0;
      if (ce_at >= 0 && k == ce_at + 3) ce = 1'b1;
      if (k == re_at) begin
        start = 1'b1;
        din0  = 25'd77;
        din1  = 16'd5;
      end
      if (re_at >= 0 && k == re_at + 1) start = 1'b0;
      @(posedge clk);
      k++;
      @(negedge clk);
      seen = done;
      if (re_at >= 0 && k == re_at + 1)
        chk({tag, ":busy_hold"}, int'(busy), 1);
    end
    start = 1'b0;
    ce    = 1'b1;
    chk({tag, ":latency"}, k, lat);
    chk({tag, ":dout"}, int'($signed(dout)), q);
    chk({tag, ":rem"}, int'($signed(rem)), r);
    chk({tag, ":ovf"}, int'(ovf), ov);
    chk({tag, ":dbz"}, int'(dbz), bz);
    if (re_at >= 0) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, ":one_done"}, extra, 0);
      chk({tag, ":hold_dout"}, int'($signed(dout)), q);
    end
  endtask

  initial begin
    longint a, b;
    logic [24:0] t;
    rst_n = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    #1;
    chk("rst:busy", int'(busy), 0);
    chk("rst:done", int'(done), 0);
    chk("rst:dout", int'(dout), 0);
    chk("rst:rem",  int'(rem), 0);
    chk("rst:flags", int'({ovf, dbz}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(1000, 7, -1, -1, "t1");
    op(-1000, 7, -1, -1, "t2a");
    op(-(64'sd1 << 24), 1, -1, -1, "t2b");
    op(100000, 3, -1, -1, "t3");
    op(5, 0, -1, -1, "t4a");
    op(-5, 0, -1, -1, "t4b");
    op(0, 123, -1, -1, "zero");
    op(-2560, 10, -1, -1, "min_exact");
    op(2550, 10, -1, -1, "max_exact");
    op(12345, 97, 8, -1, "ce_gap");
    op(-4321, 19, -1, 6, "restart");

    @(negedge clk);
    din0  = 25'd1234567;
    din1  = 16'd89;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst:busy", int'(busy), 0);
    chk("arst:done", int'(done), 0);
    chk("arst:dout", int'(dout), 0);
    chk("arst:rem",  int'(rem), 0);
    chk("arst:flags", int'({ovf, dbz}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(-777, 13, -1, -1, "post_rst");

    for (int i = 0; i < 20; i++) begin
      t = 25'($urandom);
      a = longint'($signed(t));
      a = a >>> $urandom_range(0, 22);
      if (i % 3 == 0) b = longint'($urandom_range(1, 65535));
      else            b = longint'($urandom_range(1, 300));
      op(a, b, -1, -1, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
